// File: rtl/signature_dump_ctrl.sv
// signature_dump_ctrl: register-programmed signature dump engine.
// Reads words in [BEGIN, END) as a bus host and streams them out.
module signature_dump_ctrl #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned CountWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dev_req_i,
  input  logic                 dev_we_i,
  input  logic [AddrWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0] dev_wdata_i,
  input  logic [3:0]           dev_be_i,
  output logic                 dev_rvalid_o,
  output logic [DataWidth-1:0] dev_rdata_o,
  output logic                 dev_err_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 sig_valid_o,
  input  logic                 sig_ready_i,
  output logic [DataWidth-1:0] sig_data_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StPush,
    StDone
  } state_e;

  localparam logic [DataWidth-1:0] AlignMask =
    {{(DataWidth-2){1'b1}}, 2'b00};

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  beg_q, beg_d;
  logic [DataWidth-1:0]  end_q, end_d;
  logic [AddrWidth-1:0]  ptr_q, ptr_d, ptr_inc;
  logic [AddrWidth-1:0]  beg_a, end_a;
  logic [CountWidth-1:0] cnt_q, cnt_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;
  logic                  rvalid_q;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;

  logic [7:0]            off;
  logic                  busy;
  logic [DataWidth-1:0]  wmask;
  logic [DataWidth-1:0]  status;
  logic                  wr_beg, wr_end, start;
  logic                  unused_addr;

  assign off    = dev_addr_i[9:2];
  assign busy   = (state_q == StReq) | (state_q == StWait) |
                  (state_q == StPush);
  assign wmask  = {{8{dev_be_i[3]}}, {8{dev_be_i[2]}},
                   {8{dev_be_i[1]}}, {8{dev_be_i[0]}}};
  assign status = {16'(cnt_q), 13'b0, err_q,
                   state_q == StDone, busy};
  assign beg_a  = AddrWidth'(beg_q);
  assign end_a  = AddrWidth'(end_q);
  assign ptr_inc = ptr_q + AddrWidth'(4);

  assign unused_addr = ^{dev_addr_i[AddrWidth-1:10],
                         dev_addr_i[1:0]};

  // Device port decode: read mux, access errors, write strobes
  always_comb begin
    rdata_d = '0;
    rerr_d  = 1'b0;
    wr_beg  = 1'b0;
    wr_end  = 1'b0;
    start   = 1'b0;
    if (dev_req_i) begin
      unique case (1'b1)
        off == 8'd0: begin
          if (!dev_we_i) rdata_d = beg_q;
          else if (busy) rerr_d = 1'b1;
          else wr_beg = 1'b1;
        end
        off == 8'd1: begin
          if (!dev_we_i) rdata_d = end_q;
          else if (busy) rerr_d = 1'b1;
          else wr_end = 1'b1;
        end
        off == 8'd2: begin
          if (dev_we_i) begin
            if (busy) rerr_d = 1'b1;
            else start = dev_wdata_i[0] & dev_be_i[0];
          end
        end
        off == 8'd3: begin
          if (dev_we_i) rerr_d = 1'b1;
          else rdata_d = status;
        end
        default: rerr_d = 1'b1;
      endcase
    end
  end

  // Byte-merged writes of the word-aligned range registers
  always_comb begin
    beg_d = beg_q;
    end_d = end_q;
    if (wr_beg)
      beg_d = ((beg_q & ~wmask) | (dev_wdata_i & wmask)) & AlignMask;
    if (wr_end)
      end_d = ((end_q & ~wmask) | (dev_wdata_i & wmask)) & AlignMask;
  end

  // Dump engine next state; the stream valid is registered,
  // so PUSH spends one cycle loading it before offering the word
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          ptr_d   = beg_a;
          state_d = (beg_a < end_a) ? StReq : StDone;
        end
      end
      StReq: begin
        if (host_gnt_i) state_d = StWait;
      end
      StWait: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            data_d  = host_rdata_i;
            state_d = StPush;
          end
        end
      end
      StPush: begin
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (sig_ready_i) begin
          vld_d = 1'b0;
          ptr_d = ptr_inc;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          state_d = (ptr_inc >= end_a || ptr_inc == '0) ?
                    StDone : StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Device response pipeline and range registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      beg_q    <= '0;
      end_q    <= '0;
    end else begin
      rvalid_q <= dev_req_i;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      beg_q    <= beg_d;
      end_q    <= end_d;
    end
  end

  // Dump engine state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign dev_rvalid_o = rvalid_q;
  assign dev_rdata_o  = rdata_q;
  assign dev_err_o    = rerr_q;
  assign host_req_o   = (state_q == StReq);
  assign host_addr_o  = (state_q == StReq) ? ptr_q : '0;
  assign sig_valid_o  = vld_q;
  assign sig_data_o   = data_q;
  assign done_o       = (state_q == StDone);
  assign err_o        = err_q;

endmodule

// File: tb/tb_signature_dump_ctrl.sv
// tb_signature_dump_ctrl: scoreboard bench for the dump engine.
// Expected beats and register responses come from a range model.
module tb_signature_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dev_req_i = 1'b0, dev_we_i = 1'b0;
  logic [31:0] dev_addr_i = '0, dev_wdata_i = '0;
  logic [3:0]  dev_be_i = '0;
  logic        dev_rvalid_o, dev_err_o;
  logic [31:0] dev_rdata_o;
  logic        host_req_o;
  logic        host_gnt_i = 1'b0;
  logic [31:0] host_addr_o;
  logic        host_rvalid_i = 1'b0, host_err_i = 1'b0;
  logic [31:0] host_rdata_i = '0;
  logic        sig_valid_o;
  logic        sig_ready_i = 1'b1;
  logic [31:0] sig_data_o;
  logic        done_o, err_o;

  always #5 clk = ~clk;

  signature_dump_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i),
    .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
    .dev_be_i(dev_be_i), .dev_rvalid_o(dev_rvalid_o),
    .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i),
    .host_addr_o(host_addr_o), .host_rvalid_i(host_rvalid_i),
    .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .sig_valid_o(sig_valid_o), .sig_ready_i(sig_ready_i),
    .sig_data_o(sig_data_o), .done_o(done_o), .err_o(err_o)
  );

  localparam logic [31:0] Base = 32'h1000_0000;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h want none", nm, act);
  endtask

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
    bit          cd;
  } dexp_t;

  dexp_t       dq[$];
  dexp_t       dx;
  logic [31:0] sq[$];
  int          hs_cyc[$];
  int          hs_count = 0;

  logic [31:0] ram [int unsigned];
  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // bus slave model
  int gnt_lo = 0, gnt_hi = 0, rv_lo = 0, rv_hi = 0;
  int err_at = -1, rd_idx = 0;
  int gwait = 0, pend_wait = 0;
  bit pend = 0, gnt_issued = 0;
  logic [31:0] gaddr = '0;

  always @(posedge clk) begin
    #1;
    host_gnt_i = 1'b0;
    host_rvalid_i = 1'b0;
    host_err_i = 1'b0;
    host_rdata_i = '0;
    if (!rst_ni) begin
      pend = 0;
      gnt_issued = 0;
    end else begin
      if (gnt_issued) begin
        pend = 1;
        gnt_issued = 0;
        pend_wait = $urandom_range(rv_hi, rv_lo);
      end
      if (pend) begin
        if (pend_wait == 0) begin
          host_rvalid_i = 1'b1;
          host_rdata_i = memrd(gaddr);
          host_err_i = (rd_idx == err_at);
          pend = 0;
          rd_idx++;
        end else pend_wait--;
      end
      if (host_req_o) begin
        chk("one_outstanding", 64'(pend), 0);
        chk("addr_align", 64'(host_addr_o[1:0]), 0);
        if (gwait == 0) begin
          host_gnt_i = 1'b1;
          gnt_issued = 1;
          gaddr = host_addr_o;
          gwait = $urandom_range(gnt_hi, gnt_lo);
        end else gwait--;
      end
    end
  end

  // stream sink ready
  int stall_beat = -1, stall_left = 0;
  bit rdy_rand = 0;
  always @(posedge clk) begin
    #1;
    if (sig_valid_o && hs_count == stall_beat && stall_left > 0) begin
      sig_ready_i = 1'b0;
      stall_left--;
    end else begin
      sig_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // stream monitor
  logic [31:0] prev_d = '0;
  bit prev_stall = 0;
  always @(negedge clk) begin
    if (rst_ni && sig_valid_o) begin
      if (prev_stall) chk("sig_hold", 64'(sig_data_o), 64'(prev_d));
      chk("no_req_in_push", 64'(host_req_o), 0);
      if (sig_ready_i) begin
        if (sq.size() == 0) fail_now("unexpected_beat", 64'(sig_data_o));
        else chk("beat", 64'(sig_data_o), 64'(sq.pop_front()));
        hs_cyc.push_back(cyc);
        hs_count++;
        prev_stall = 0;
      end else begin
        prev_stall = 1;
        prev_d = sig_data_o;
      end
    end else prev_stall = 0;
  end

  // device response monitor
  always @(negedge clk) begin
    if (rst_ni) begin
      if (dq.size() > 0 && dq[0].due == cyc) begin
        dx = dq.pop_front();
        chk("dev_rvalid", 64'(dev_rvalid_o), 1);
        chk("dev_err", 64'(dev_err_o), 64'(dx.e));
        if (dx.cd) chk("dev_rdata", 64'(dev_rdata_o), 64'(dx.d));
      end else if (dev_rvalid_o) begin
        fail_now("unexpected_rvalid", 64'(dev_rdata_o));
      end
    end
  end

  task automatic dev_acc(input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] ed, input bit ee,
                         input bit cd);
    dexp_t x;
    dev_req_i = 1'b1;
    dev_we_i = we;
    dev_addr_i = addr;
    dev_wdata_i = wd;
    dev_be_i = be;
    x.due = cyc + 1;
    x.d = ed;
    x.e = ee;
    x.cd = cd;
    dq.push_back(x);
    @(posedge clk);
    #1;
    dev_req_i = 1'b0;
    dev_we_i = 1'b0;
  endtask

  // register model
  logic [31:0] mbeg = '0, mend = '0;
  int exp_cnt = 0;
  bit exp_err = 0;
  int done_cyc = 0;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic wr(input int off, input logic [31:0] d,
                    input logic [3:0] be, input bit busy);
    bit e;
    e = (off > 2) || busy;
    if (!e && off == 0) mbeg = merge(mbeg, d, be);
    if (!e && off == 1) mend = merge(mend, d, be);
    dev_acc(1, Base + 32'(off * 4), d, be, '0, e, 0);
  endtask

  task automatic rd(input int off, input logic [31:0] ed,
                    input bit ee);
    dev_acc(0, Base + 32'(off * 4), '0, 4'hF, ed, ee, !ee);
  endtask

  task automatic start_dump(input logic [31:0] b, input logic [31:0] e,
                            input int ea, input int gh, input int rl,
                            input int rh, input bit rr);
    longint a;
    int i;
    err_at = ea;
    rd_idx = 0;
    gnt_lo = gh;
    gnt_hi = gh;
    gwait = gh;
    rv_lo = rl;
    rv_hi = rh;
    rdy_rand = rr;
    hs_cyc.delete();
    hs_count = 0;
    wr(0, b, 4'hF, 0);
    wr(1, e, 4'hF, 0);
    exp_cnt = 0;
    exp_err = 0;
    if (mbeg < mend) begin
      a = longint'(mbeg);
      i = 0;
      forever begin
        if (i == err_at) begin
          exp_err = 1;
          break;
        end
        sq.push_back(memrd(a[31:0]));
        exp_cnt++;
        a += 4;
        i++;
        if (a >= longint'(mend) || a == 64'h1_0000_0000) break;
      end
    end
    wr(2, 32'h1, 4'hF, 0);
  endtask

  task automatic finish_dump();
    int n;
    n = 0;
    while (!done_o && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done", 64'(done_o), 1);
    done_cyc = cyc;
    chk("err_o", 64'(err_o), 64'(exp_err));
    chk("beats_left", 64'(sq.size()), 0);
    rd(3, {16'(exp_cnt), 13'b0, exp_err, 1'b1, 1'b0}, 0);
    sq.delete();
  endtask

  function automatic logic any_out();
    return |{dev_rvalid_o, dev_rdata_o, dev_err_o, host_req_o,
             host_addr_o, sig_valid_o, sig_data_o, done_o, err_o};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int e0, n, len;
  logic [31:0] rb, re;

  initial begin
    ram[32'h2000] = 32'h11;
    ram[32'h2004] = 32'h22;
    ram[32'h2008] = 32'h33;
    ram[32'h200C] = 32'h44;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(any_out()), 0);
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    rd(0, 0, 0);
    rd(1, 0, 0);
    rd(3, 0, 0);

    wr(0, 32'hAABB_CCDD, 4'b0010, 0);
    rd(0, mbeg, 0);
    chk("byte_model", 64'(mbeg), 64'h0000_CC00);

    start_dump(32'h3000, 32'h3000, -1, 0, 0, 0, 0);
    chk("empty_done", 64'(done_o), 1);
    chk("empty_noreq", 64'(host_req_o), 0);
    finish_dump();

    start_dump(32'h2000, 32'h2010, -1, 0, 0, 0, 0);
    e0 = cyc;
    chk("req_at_start", 64'(host_req_o), 1);
    finish_dump();
    chk("beat_n", 64'(hs_cyc.size()), 4);
    if (hs_cyc.size() == 4) begin
      chk("first_lat", 64'(hs_cyc[0] - e0), 3);
      for (int i = 1; i < 4; i++)
        chk("period", 64'(hs_cyc[i] - hs_cyc[i-1]), 4);
      chk("done_lat", 64'(done_cyc - hs_cyc[3]), 1);
    end

    stall_beat = 1;
    stall_left = 5;
    start_dump(32'h2000, 32'h2010, -1, 0, 0, 0, 0);
    finish_dump();
    chk("stall_used", 64'(stall_left), 0);
    stall_beat = -1;

    start_dump(32'h2000, 32'h2010, 1, 0, 0, 0, 0);
    finish_dump();

    start_dump(32'h2000, 32'h2010, -1, 15, 0, 0, 0);
    wr(1, 32'h9999, 4'hF, 1);
    rd(1, mend, 0);
    rd(3, 32'h1, 0);
    dev_acc(0, Base + 32'h10, '0, 4'hF, '0, 1, 0);
    wr(2, 32'h1, 4'hF, 1);
    wr(3, 32'h0, 4'hF, 0);
    finish_dump();

    start_dump(32'h2008, 32'h2000, -1, 0, 0, 0, 0);
    finish_dump();
    start_dump(32'h200C, 32'h2010, -1, 0, 0, 0, 0);
    finish_dump();

    start_dump(32'h2000, 32'h2010, -1, 0, 50, 50, 0);
    n = 0;
    while (!host_gnt_i && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("got_gnt", 64'(host_gnt_i), 1);
    @(posedge clk);
    #1;
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset_outputs", 64'(any_out()), 0);
    sq.delete();
    mbeg = '0;
    mend = '0;
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("quiet", 64'({host_req_o, sig_valid_o}), 0);
    end
    rd(3, 0, 0);
    rd(0, 0, 0);
    start_dump(32'h2000, 32'h2010, -1, 0, 0, 0, 0);
    finish_dump();

    for (int t = 0; t < 8; t++) begin
      rb = 32'h4000 + 32'($urandom_range(0, 63) * 4) +
           32'($urandom_range(0, 3));
      len = $urandom_range(0, 6);
      re = (rb & ~32'h3) + 32'(len * 4) + 32'($urandom_range(0, 3));
      if (t == 3) re = rb - 32'h10;
      start_dump(rb, re,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1,
                 $urandom_range(0, 2), 0, $urandom_range(0, 2), 1);
      finish_dump();
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signature_dump_ctrl.md
# signature_dump_ctrl

Memory-mapped signature extraction engine for the compliance simulation top. It exposes a device port holding signature begin/end address registers. On a START command it becomes a bus host, reads the signature region word by word from RAM, and streams each word to the testbench over a valid/ready port. Completion is flagged on `done_o`, which the simulation harness uses to end the run and compare signatures.

## Interface
Parameters:
- `AddrWidth`, 32: bus address width.
- `DataWidth`, 32: bus data width; fixed at 32 for this block.
- `CountWidth`, 16: width of the dumped-word counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` input 1: system clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `dev_req_i` input 1: device access request; always accepted in the same cycle.
- `dev_we_i` input 1: write enable.
- `dev_addr_i` input AddrWidth: byte address; only bits [9:2] are decoded.
- `dev_wdata_i` input 32: write data.
- `dev_be_i` input 4: byte enables.
- `dev_rvalid_o` output 1: response valid.
- `dev_rdata_o` output 32: read data.
- `dev_err_o` output 1: response error, qualified by `dev_rvalid_o`.
- `host_req_o` output 1: bus read request.
- `host_gnt_i` input 1: bus grant.
- `host_addr_o` output AddrWidth: read address, word aligned.
- `host_rvalid_i` input 1: read data valid.
- `host_rdata_i` input 32: read data.
- `host_err_i` input 1: read error, qualified by `host_rvalid_i`.
- `sig_valid_o` output 1: signature word valid.
- `sig_ready_i` input 1: testbench accepts the word.
- `sig_data_o` output 32: signature word.
- `done_o` output 1: dump complete (level).
- `err_o` output 1: dump aborted on a bus error (level).

## Operation
Register map (offset from device base):
- 0x00 `BEGIN`: RW; bits [1:0] read 0 and ignore writes.
- 0x04 `END`: RW; exclusive bound; bits [1:0] read 0 and ignore writes.
- 0x08 `START`: WO; a write with wdata[0]=1 starts a dump; reads return 0.
- 0x0C `STATUS`: RO; bit0 = busy, bit1 = done, bit2 = err, bits[31:16] = words dumped.
- Writes honour `dev_be_i` per byte.
- Any other offset, or a write to `STATUS`, gives `dev_err_o=1` with no state change.
- A write to `BEGIN`, `END` or `START` while busy gives `dev_err_o=1` and is ignored.

FSM states: IDLE, REQ, WAIT, PUSH, DONE.
- IDLE or DONE, START accepted:
  - Clear done, err and count.
  - Set ptr = `BEGIN`.
  - Go to REQ if `BEGIN` < `END` (unsigned compare), else go to DONE with count 0.
- REQ: drive `host_req_o=1` and `host_addr_o=ptr`. Hold both stable until `host_gnt_i`, then go to WAIT.
- WAIT: `host_req_o=0`. On `host_rvalid_i`:
  - with `host_err_i=1`: set err and go to DONE;
  - otherwise capture `host_rdata_i` into the output register and go to PUSH.
- PUSH: `sig_valid_o=1` with `sig_data_o` stable until `sig_ready_i`. On the handshake:
  - ptr += 4 (wraps modulo 2^AddrWidth); count += 1 (saturates at all-ones);
  - go to DONE if new ptr >= `END` or new ptr wrapped to 0, else go to REQ.
- DONE: `done_o=1`; `err_o` reflects err. Stays in DONE until the next START.
- Busy = state in {REQ, WAIT, PUSH}.
- At most one outstanding host request at any time.

## Timing
- Reset values:
  - all outputs 0; `BEGIN`, `END`, count, ptr and the data register 0;
  - state IDLE.
- Reset mid-dump aborts immediately. No further host requests or stream beats are issued.
- Device port: `dev_rvalid_o` is asserted exactly one cycle after `dev_req_i`, with `dev_rdata_o`/`dev_err_o` valid in that same cycle. Back-to-back requests get back-to-back responses.
- A register write is visible to a read issued the following cycle.
- START accepted in cycle N: state is REQ (or DONE if the range is empty) in cycle N+1.
- Host read with zero-wait grant and rvalid one cycle after gnt: `sig_valid_o` rises 3 cycles after REQ entry.
- `sig_ready_i` held high: the minimum per-word period is 4 cycles.
- `done_o` rises the cycle after the final handshake or the erroring rvalid.
- A device-port access coincident with any host-side event is handled independently. A same-cycle `STATUS` read returns the pre-update value.

## Test plan
- Write `BEGIN`=0x2000 and `END`=0x2010 with RAM preloaded 0x11..0x44, then START, with ready always high -> exactly 4 beats of 0x11, 0x22, 0x33, 0x44 at addresses 0x2000–0x200C; `done_o`=1; `STATUS`=0x0004_0002.
- Same dump with `sig_ready_i` low for 5 cycles on beat 2 -> `sig_data_o` held at 0x22, no new host request issued, order preserved.
- `BEGIN`=`END`=0x3000, START -> no `host_req_o`; `done_o`=1 in the next cycle; count 0.
- `host_err_i`=1 on the second read -> 1 beat only; `err_o`=1 and `done_o`=1; `STATUS`=0x0001_0006.
- Write `END` while busy, or access offset 0x10 -> `dev_err_o`=1 one cycle later and `END` unchanged. Byte write be=0b0010 of 0xAABBCCDD to `BEGIN`=0 -> `BEGIN` reads 0x0000_CC00.
- Assert `rst_ni` low during WAIT -> all outputs 0 and state IDLE. A new START after release completes a normal dump.
